seg7_decoder: RTL and testbench
===============================

SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical synchronized samples needed to accept a pattern; legal range 1..255.
REQ-002 clk  input  1  single clock; every register in the block is clocked by its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 seg_n  input  7  segment pattern, active-low; bit0 = segment a through bit6 = segment g; asynchronous to clk.
REQ-005 out_ready  input  1  consumer accepts the current output when out_valid=1.
REQ-006 ovr_clr  input  1  synchronous clear of out_overrun.
REQ-007 out_valid  output  1  decoded event pending.
REQ-008 out_digit  output  4  decoded value 0..9; 4'h0 when out_err or out_blank is 1.
REQ-009 out_blank  output  1  event is the all-off pattern 7'b1111111.
REQ-010 out_err  output  1  event is a pattern that is not 0..9 and not blank.
REQ-011 out_overrun  output  1  sticky flag: an event was dropped while an output was pending.

Function
REQ-012 seg_n shall pass through a 2-flop synchronizer before any other use.
REQ-013 A stability counter shall compare each synchronized sample with the previous synchronized sample.
REQ-014 Stability counter rules: mismatch loads 1; match increments and saturates at STABLE_CYCLES.
REQ-015 An event shall be generated in the cycle the counter first reaches STABLE_CYCLES and the sample differs from the last-accepted pattern register.
REQ-016 A pattern held stable produces exactly one event; a new event requires a different pattern to be accepted.
REQ-017 Decode uses active-high segments gfedcba = ~seg_n with this table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-018 Active-high 0000000 shall decode as blank; every other pattern shall decode as err.
REQ-019 Output-state FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 EMPTY + event: load outputs and the last-accepted register, then go to FULL.
REQ-021 FULL + out_ready=1 + no event: go to EMPTY.
REQ-022 FULL + out_ready=1 + event in the same cycle: load the new event and stay FULL; out_overrun is not set.
REQ-023 FULL + out_ready=0 + event: drop the event, hold the outputs, set out_overrun; the last-accepted register is still updated.
REQ-024 Outputs shall remain constant while FULL and out_ready=0.
REQ-025 Latency: seg_n changes and then holds; out_valid=1 after rising edge 2+STABLE_CYCLES counted from the first edge that samples the new value, when the FSM was EMPTY.
REQ-026 A pattern that changes before reaching STABLE_CYCLES samples shall generate no event (glitch rejection).
REQ-027 out_overrun shall clear on ovr_clr=1 unless a new overrun occurs in the same cycle; in that case set wins.

Reset
REQ-028 Asserting rst_n=0 shall immediately clear all of the following:
- out_valid, out_digit, out_blank, out_err, out_overrun to 0
- stability counter to 0
- both synchronizer flops to 7'b1111111
- last-accepted register to 7'b1111111 (blank)
REQ-029 FSM shall enter EMPTY on reset.
REQ-030 A blank bus after reset shall generate no event.
REQ-031 Reset asserted mid-count or while FULL shall abort all pending work; no event shall be emitted for a pattern first captured before reset deassertion.
REQ-032 Synchronous to clk after deassertion; first sample on the first rising edge after rst_n=1.

Verification
REQ-033 STABLE_CYCLES=4, out_ready=1, seg_n=~7'b1011011 held -> out_valid=1 after edge 6 for 1 cycle with out_digit=2 and out_err=0; no further event while held.
REQ-034 seg_n toggles between the patterns for 3 and 8 every 3 cycles, then settles on 8 -> only one event, out_digit=8.
REQ-035 out_ready=0: apply 5, then 7 (each stable) -> outputs hold digit 5 and out_overrun=1; raise out_ready -> out_valid drops; pulse ovr_clr -> out_overrun=0.
REQ-036 seg_n=~7'b1110110 -> out_err=1, out_digit=0; then seg_n=7'b1111111 -> out_blank=1.
REQ-037 Sweep all 128 patterns, each held 10 cycles with out_ready=1 -> 10 digit events matching REQ-017, 1 blank, 117 err, 0 overruns.
REQ-038 Assert rst_n=0 during the 3rd stable cycle of digit 4 -> all outputs 0 immediately; after release, no event occurs until 6 edges with digit 4 stable.

Source files
------------

// File: rtl/seg7_decoder.sv
// Seven-segment bus decoder: synchronizes an asynchronous active-low segment bus,
// debounces it and presents each newly accepted pattern as a single decoded event.
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic       out_ready,
  input  logic       ovr_clr,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_err,
  output logic       out_overrun
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK_N  = 7'b1111111;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Result packing: {err, blank, digit[3:0]}, active-high segments gfedcba.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0111111: decode = {2'b00, 4'd0};
      7'b0000110: decode = {2'b00, 4'd1};
      7'b1011011: decode = {2'b00, 4'd2};
      7'b1001111: decode = {2'b00, 4'd3};
      7'b1100110: decode = {2'b00, 4'd4};
      7'b1101101: decode = {2'b00, 4'd5};
      7'b1111101: decode = {2'b00, 4'd6};
      7'b0000111: decode = {2'b00, 4'd7};
      7'b1111111: decode = {2'b00, 4'd8};
      7'b1101111: decode = {2'b00, 4'd9};
      7'b0000000: decode = {2'b01, 4'd0};
      default:    decode = {2'b10, 4'd0};
    endcase
  endfunction

  logic [6:0] sync1_r, sync2_r, prev_r, last_r;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic       match_s, event_s, load_s, drop_s;
  state_t     state_r, state_nxt_s;
  logic [5:0] dec_s;

  assign match_s = (sync2_r == prev_r);
  assign dec_s   = decode(~sync2_r);

  // Stability counter next value and single-shot event detection.
  always_comb begin
    cnt_nxt_s = 8'd1;
    event_s   = 1'b0;
    if (match_s) begin
      if (cnt_r >= STABLE_C) cnt_nxt_s = STABLE_C;
      else                   cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = 8'd1;
    end
    // Only the transition into STABLE_C counts; a saturated hold does not re-fire.
    if ((cnt_nxt_s == STABLE_C) && !(match_s && (cnt_r == STABLE_C)) && (sync2_r != last_r))
      event_s = 1'b1;
    else
      event_s = 1'b0;
  end

  // Synchronizer, sample history, stability counter and last-accepted pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= BLANK_N;
      sync2_r <= BLANK_N;
      prev_r  <= BLANK_N;
      last_r  <= BLANK_N;
      cnt_r   <= 8'd0;
    end else begin
      sync1_r <= seg_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      cnt_r   <= cnt_nxt_s;
      if (event_s) last_r <= sync2_r;
    end
  end

  // Output-state FSM next state and load/drop decisions.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (event_s) begin
          load_s      = 1'b1;
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (event_s) load_s = 1'b1;
          else         state_nxt_s = EMPTY;
        end else begin
          if (event_s) drop_s = 1'b1;
          else         drop_s = 1'b0;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // FSM state and registered output fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      out_digit   <= 4'd0;
      out_blank   <= 1'b0;
      out_err     <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        out_digit <= dec_s[3:0];
        out_blank <= dec_s[4];
        out_err   <= dec_s[5];
      end
      // A new overrun wins over a simultaneous clear.
      if (drop_s)       out_overrun <= 1'b1;
      else if (ovr_clr) out_overrun <= 1'b0;
    end
  end

  assign out_valid = (state_r == FULL);

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed self-checking bench for seg7_decoder (STABLE_CYCLES = 4).
module tb_seg7_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_n;
  logic       out_ready;
  logic       ovr_clr;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_err;
  logic       out_overrun;

  int checks   = 0;
  int failures = 0;

  int         evt;
  logic [3:0] cap_digit;
  logic       cap_blank, cap_err;

  seg7_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_valid(out_valid), .out_digit(out_digit), .out_blank(out_blank),
    .out_err(out_err), .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run n cycles, counting valid cycles and capturing the last event seen.
  task automatic run_cap(input int n);
    evt = 0;
    repeat (n) begin
      tick(1);
      if (out_valid) begin
        evt++;
        cap_digit = out_digit;
        cap_blank = out_blank;
        cap_err   = out_err;
      end
    end
  endtask

  // Expected {err, blank, digit} for an active-high segment pattern.
  function automatic logic [5:0] model(input logic [6:0] hi);
    logic [6:0] tbl [10];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    model = {2'b10, 4'd0};
    if (hi == 7'b0000000) model = {2'b01, 4'd0};
    for (int d = 0; d < 10; d++)
      if (tbl[d] == hi) model = {2'b00, 4'(d)};
  endfunction

  int n_dig, n_blank, n_err, n_bad;
  logic [5:0] exp_s;

  initial begin
    rst_n = 1'b0; seg_n = 7'b1111111; out_ready = 1'b1; ovr_clr = 1'b0;
    tick(3);
    chk("rst_valid",   8'(out_valid),   8'd0);
    chk("rst_digit",   8'(out_digit),   8'd0);
    chk("rst_overrun", 8'(out_overrun), 8'd0);
    @(negedge clk); rst_n = 1'b1;
    run_cap(12);
    chk("blank_after_reset_events", 8'(evt), 8'd0);

    // Digit 2: exact latency of 6 edges, one-cycle pulse with ready high.
    seg_n = ~7'b1011011;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("lat_not_yet", 8'(out_valid), 8'd0);
    end
    tick(1);
    chk("d2_valid", 8'(out_valid), 8'd1);
    chk("d2_digit", 8'(out_digit), 8'd2);
    chk("d2_err",   8'(out_err),   8'd0);
    run_cap(12);
    chk("d2_held_no_event", 8'(evt), 8'd0);

    // Glitching between 3 and 8, then settle on 8.
    for (int k = 0; k < 4; k++) begin
      seg_n = ~7'b1001111; tick(3);
      seg_n = ~7'b1111111; tick(3);
    end
    seg_n = ~7'b1001111; tick(3);
    seg_n = ~7'b1111111;
    run_cap(12);
    chk("glitch_events", 8'(evt), 8'd1);
    chk("glitch_digit",  8'(cap_digit), 8'd8);

    // Back-pressure: 5 held pending, 7 dropped as overrun.
    out_ready = 1'b0;
    seg_n = ~7'b1101101; tick(8);
    chk("bp_valid5", 8'(out_valid), 8'd1);
    chk("bp_digit5", 8'(out_digit), 8'd5);
    seg_n = ~7'b0000111; tick(8);
    chk("bp_hold_digit", 8'(out_digit),   8'd5);
    chk("bp_overrun",    8'(out_overrun), 8'd1);
    out_ready = 1'b1; tick(1);
    chk("bp_drain_valid", 8'(out_valid),   8'd0);
    chk("bp_sticky",      8'(out_overrun), 8'd1);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    chk("bp_ovr_clr", 8'(out_overrun), 8'd0);

    // Illegal pattern then blank.
    seg_n = ~7'b1110110;
    run_cap(10);
    chk("err_events", 8'(evt), 8'd1);
    chk("err_flag",   8'(cap_err),   8'd1);
    chk("err_digit",  8'(cap_digit), 8'd0);
    chk("err_blank",  8'(cap_blank), 8'd0);
    seg_n = 7'b1111111;
    run_cap(10);
    chk("blank_events", 8'(evt), 8'd1);
    chk("blank_flag",   8'(cap_blank), 8'd1);
    chk("blank_err",    8'(cap_err),   8'd0);

    // Full sweep of every bus pattern.
    n_dig = 0; n_blank = 0; n_err = 0; n_bad = 0;
    for (int p = 0; p < 128; p++) begin
      seg_n = 7'(p);
      exp_s = model(~7'(p));
      run_cap(10);
      if (evt == 1) begin
        if ({cap_err, cap_blank, cap_digit} !== exp_s) n_bad++;
        if (cap_err) n_err++;
        else if (cap_blank) n_blank++;
        else n_dig++;
      end else begin
        n_bad++;
      end
    end
    chk("sweep_digits",     8'(n_dig),   8'd10);
    chk("sweep_blank",      8'(n_blank), 8'd1);
    chk("sweep_err",        8'(n_err),   8'd117);
    chk("sweep_mismatches", 8'(n_bad),   8'd0);
    chk("sweep_overrun",    8'(out_overrun), 8'd0);

    // Reset while FULL with an overrun, mid-count of digit 4.
    out_ready = 1'b0;
    seg_n = ~7'b1101111; tick(8);
    chk("pre_rst_digit9", 8'(out_digit), 8'd9);
    seg_n = ~7'b0000110; tick(8);
    chk("pre_rst_overrun", 8'(out_overrun), 8'd1);
    seg_n = ~7'b1100110; tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",   8'(out_valid),   8'd0);
    chk("rst_mid_digit",   8'(out_digit),   8'd0);
    chk("rst_mid_overrun", 8'(out_overrun), 8'd0);
    chk("rst_mid_err",     8'(out_err),     8'd0);
    chk("rst_mid_blank",   8'(out_blank),   8'd0);
    tick(2);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("post_rst_not_yet", 8'(out_valid), 8'd0);
    end
    tick(1);
    chk("post_rst_valid", 8'(out_valid), 8'd1);
    chk("post_rst_digit", 8'(out_digit), 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
